// File: rtl/clock_divider_ctrl_pkg.sv
// Shared state encoding and constants for the SPI clock divider reconfiguration controller.
package clock_divider_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int DIV_RESET_CYCLES = 2;
    localparam int FACTOR_W_DEFAULT = 5;

endpackage

// File: rtl/clock_divider_controller_settle_counter.sv
// Loadable down-counter timing the APPLY and SETTLE dwells.
// o_terminal marks the last cycle of a loaded dwell; the count then rests at zero (o_idle).
module settle_counter #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_terminal,
    output logic             o_idle
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == CNT_W'(1));
    assign o_idle     = (r_count == '0);

endmodule

// File: rtl/clock_divider_controller.sv
// Sequences run-time divide-factor changes: stage, wait for SPI idle, pulse the divider
// reset with the new factor, settle, then re-open SPI start grants.
module clock_divider_controller
    import clock_divider_ctrl_pkg::*;
#(
    parameter int FACTOR_W      = FACTOR_W_DEFAULT,
    parameter int MAX_FACTOR    = 31,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                input_clock,
    input  logic                reset,
    input  logic [FACTOR_W-1:0] cfg_factor,
    input  logic                cfg_update,
    input  logic                spi_busy,
    input  logic                spi_start_req,
    output logic                spi_start_gnt,
    output logic [FACTOR_W-1:0] div_factor,
    output logic                div_reset,
    output logic                cfg_pending,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_error,
    output state_t              dbg_state
);

    localparam int               CNT_W       = $clog2(SETTLE_CYCLES + DIV_RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] APPLY_LOAD  = CNT_W'(DIV_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam bit               SKIP_SETTLE = (SETTLE_CYCLES == 1);
    localparam logic [31:0]      MAX_U       = 32'(MAX_FACTOR);

    state_t              r_state;
    logic [FACTOR_W-1:0] r_div_factor;
    logic [FACTOR_W-1:0] r_staged;
    logic                r_div_reset;
    logic                r_pending;
    logic                r_ready;
    logic                r_done;
    logic                r_error;
    logic                r_gnt;
    logic                r_again;

    logic             w_valid;
    logic             w_again;
    logic             w_finish;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_value;
    logic             w_cnt_terminal;
    logic             w_cnt_idle;

    assign w_valid = cfg_update && (32'(cfg_factor) <= MAX_U);
    assign w_again = r_again || w_valid;

    // APPLY always starts with the counter idle: the first APPLY cycle arms the reset dwell,
    // its terminal cycle arms the settle dwell, so reset entry and update entry time alike.
    assign w_cnt_load       = (r_state == APPLY) && (w_cnt_idle || w_cnt_terminal);
    assign w_cnt_load_value = w_cnt_idle ? APPLY_LOAD : SETTLE_LOAD;
    assign w_finish         = w_cnt_terminal &&
                              ((r_state == SETTLE) || (SKIP_SETTLE && (r_state == APPLY)));

    settle_counter #(
        .CNT_W(CNT_W)
    ) u_settle_counter (
        .i_clk       (input_clock),
        .i_rst       (reset),
        .i_load      (w_cnt_load),
        .i_load_value(w_cnt_load_value),
        .o_terminal  (w_cnt_terminal),
        .o_idle      (w_cnt_idle)
    );

    always_ff @(posedge input_clock) begin
        if (reset) begin
            r_state      <= APPLY;
            r_div_reset  <= 1'b1;
            r_div_factor <= '0;
            r_staged     <= '0;
            r_pending    <= 1'b0;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_gnt        <= 1'b0;
            r_again      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_gnt  <= (r_state == RUN) && spi_start_req && !cfg_update && !r_gnt;
            if (cfg_update) begin
                r_error <= !w_valid;
            end
            case (r_state)
                RUN: begin
                    if (w_valid) begin
                        r_staged <= cfg_factor;
                        if (cfg_factor == r_div_factor) begin
                            r_done <= 1'b1;
                        end else if (!spi_busy) begin
                            r_state      <= APPLY;
                            r_div_reset  <= 1'b1;
                            r_div_factor <= cfg_factor;
                            r_ready      <= 1'b0;
                        end else begin
                            r_state   <= PENDING;
                            r_pending <= 1'b1;
                            r_ready   <= 1'b0;
                        end
                    end
                end
                PENDING: begin
                    if (w_valid) begin
                        r_staged <= cfg_factor;
                    end
                    if (!spi_busy) begin
                        r_state      <= APPLY;
                        r_div_reset  <= 1'b1;
                        r_pending    <= 1'b0;
                        r_div_factor <= w_valid ? cfg_factor : r_staged;
                    end
                end
                APPLY, SETTLE: begin
                    if (w_valid) begin
                        r_staged  <= cfg_factor;
                        r_again   <= 1'b1;
                        r_pending <= 1'b1;
                    end
                    if ((r_state == APPLY) && w_cnt_terminal) begin
                        r_div_reset <= 1'b0;
                        if (!SKIP_SETTLE) begin
                            r_state <= SETTLE;
                        end
                    end
                end
                default: r_state <= APPLY;
            endcase
            // A factor that arrived mid-sequence supersedes the one just applied.
            if (w_finish) begin
                if (w_again) begin
                    r_state <= PENDING;
                    r_again <= 1'b0;
                end else begin
                    r_state <= RUN;
                    r_ready <= 1'b1;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign spi_start_gnt = r_gnt;
    assign div_factor    = r_div_factor;
    assign div_reset     = r_div_reset;
    assign cfg_pending   = r_pending;
    assign cfg_ready     = r_ready;
    assign cfg_done      = r_done;
    assign cfg_error     = r_error;
    assign dbg_state     = r_state;

endmodule
